// File: rtl/mem_arbiter.sv
// Two-port word arbiter and sequencer in front of the mems container (lomem/pmon/himem).
// Define MEM_ARB_FIXED_PRIO_EN for fixed port-0 priority; default build uses round-robin.
module mem_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned LOMEM_SIZE = 65536,
    parameter logic [31:0] PMON_BASE  = 32'h0000_F000,
    parameter int unsigned PMON_SIZE  = 4096,
    parameter logic [31:0] HIMEM_BASE = 32'h0001_0000,
    parameter int unsigned HIMEM_SIZE = 65536
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             wen0,
    input  logic             wen1,
    input  logic [31:0]      addr0,
    input  logic [31:0]      addr1,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic             ack0,
    output logic             ack1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH-1:0] dout0,
    output logic [WIDTH-1:0] dout1,
    output logic [31:0]      mem_addr,
    output logic [WIDTH-1:0] mem_din,
    output logic             mem_wen,
    output logic             cs_lomem,
    output logic             cs_pmon,
    output logic             cs_himem,
    input  logic [WIDTH-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Bounds are widened to 33 bits so base+size never wraps at the top of the address space.
    localparam logic [32:0] LOMEM_HI = 33'(LOMEM_SIZE);
    localparam logic [32:0] PMON_LO  = {1'b0, PMON_BASE};
    localparam logic [32:0] PMON_HI  = {1'b0, PMON_BASE} + 33'(PMON_SIZE);
    localparam logic [32:0] HIMEM_LO = {1'b0, HIMEM_BASE};
    localparam logic [32:0] HIMEM_HI = {1'b0, HIMEM_BASE} + 33'(HIMEM_SIZE);
    localparam bit          HIMEM_EN = (HIMEM_SIZE != 0);

    state_t           state;
    logic             owner;
    logic             err_flag;
    logic             rd_flag;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic             rr_last;
`endif

    logic             grant;
    logic [31:0]      sel_addr;
    logic [WIDTH-1:0] sel_din;
    logic             sel_wen;
    logic [32:0]      wide_addr;
    logic             hit_pmon;
    logic             hit_lomem;
    logic             hit_himem;
    logic             mapped;

    // Pick the winning port and decode its address; pmon shadows the top of lomem.
    always_comb begin
        grant = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        grant = !req0;
`else
        if (req0 && req1) begin
            grant = !rr_last;
        end else begin
            grant = !req0;
        end
`endif
        sel_addr  = grant ? addr1 : addr0;
        sel_din   = grant ? din1  : din0;
        sel_wen   = grant ? wen1  : wen0;
        wide_addr = {1'b0, sel_addr};
        hit_pmon  = (wide_addr >= PMON_LO) && (wide_addr < PMON_HI);
        hit_lomem = !hit_pmon && (wide_addr < LOMEM_HI);
        hit_himem = !hit_pmon && !hit_lomem && HIMEM_EN &&
                    (wide_addr >= HIMEM_LO) && (wide_addr < HIMEM_HI);
        mapped    = hit_pmon || hit_lomem || hit_himem;
    end

    // Sequencer: grant in IDLE, hold the bus one cycle in ACCESS, respond in RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            err_flag <= 1'b0;
            rd_flag  <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_last  <= 1'b1;
`endif
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            dout0    <= '0;
            dout1    <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_wen  <= 1'b0;
            cs_lomem <= 1'b0;
            cs_pmon  <= 1'b0;
            cs_himem <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                    dout0 <= '0;
                    dout1 <= '0;
                    if (req0 || req1) begin
                        owner    <= grant;
                        err_flag <= !mapped;
                        rd_flag  <= !sel_wen;
                        mem_addr <= sel_addr;
                        mem_din  <= sel_din;
                        mem_wen  <= sel_wen && mapped;
                        cs_lomem <= hit_lomem;
                        cs_pmon  <= hit_pmon;
                        cs_himem <= hit_himem;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        rr_last  <= grant;
`endif
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_wen  <= 1'b0;
                    cs_lomem <= 1'b0;
                    cs_pmon  <= 1'b0;
                    cs_himem <= 1'b0;
                    state    <= RESP;
                end
                RESP: begin
                    ack0  <= !owner;
                    ack1  <= owner;
                    err0  <= !owner && err_flag;
                    err1  <= owner && err_flag;
                    dout0 <= (!owner && rd_flag && !err_flag) ? mem_dout : '0;
                    dout1 <= (owner && rd_flag && !err_flag) ? mem_dout : '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
